bcd_serial_adder_ctrl: RTL

Sequencer that adds two NDIG-digit packed-BCD operands using one shared BCD digit adder, one digit per clock, least-significant digit first. It latches the operands on a start pulse, ripples the decimal carry through a register, and reports the result with a one-cycle done pulse. It sits between a host or register interface and the single-digit BCD add/correct datapath, so wide decimal adds reuse one 4-bit adder instead of NDIG parallel copies.

---
 rtl/bcd_pkg.sv | 11 +
 rtl/bcd_serial_adder_ctrl_if.sv | 14 +
 rtl/bcd_digit_add.sv | 19 +
 rtl/bcd_serial_adder_ctrl.sv | 86 ++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// bcd_pkg: shared constants, FSM state type and digit extraction for the serial BCD adder.
package bcd_pkg;
   localparam int DIGIT_W = 4;
   localparam int BCD_MAX = 9;
   localparam int BCD_ADJ = 6;
   localparam int MAX_W = 256;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   function automatic logic [DIGIT_W-1:0] get_digit(input logic [MAX_W-1:0] v, input int i);
      return v[i*DIGIT_W +: DIGIT_W];
   endfunction
endpackage

// File: rtl/bcd_serial_adder_ctrl_if.sv
// bcd_serial_adder_ctrl_if: host-side request/result bundle of the serial BCD adder.
interface bcd_serial_adder_ctrl_if #(parameter int NDIG = 4);
   logic            start;
   logic [4*NDIG-1:0] a;
   logic [4*NDIG-1:0] b;
   logic            cin;
   logic            busy;
   logic            done;
   logic [4*NDIG-1:0] sum;
   logic            cout;
   logic            err;
   modport master (output start, a, b, cin, input busy, done, sum, cout, err);
   modport slave  (input start, a, b, cin, output busy, done, sum, cout, err);
endinterface

// File: rtl/bcd_digit_add.sv
// bcd_digit_add: one decimal digit add with +6 correction and invalid-digit flag.
module bcd_digit_add
   import bcd_pkg::*;
(
   input  logic [DIGIT_W-1:0] a_d,
   input  logic [DIGIT_W-1:0] b_d,
   input  logic               ci,
   output logic [DIGIT_W-1:0] s,
   output logic               co,
   output logic               bad
);
   logic [DIGIT_W:0] t;
   always_comb begin
      t   = {1'b0, a_d} + {1'b0, b_d} + {{DIGIT_W{1'b0}}, ci};
      co  = t > (DIGIT_W+1)'(BCD_MAX);
      s   = co ? DIGIT_W'(t + (DIGIT_W+1)'(BCD_ADJ)) : t[DIGIT_W-1:0];
      bad = (a_d > DIGIT_W'(BCD_MAX)) || (b_d > DIGIT_W'(BCD_MAX));
   end
endmodule

// File: rtl/bcd_serial_adder_ctrl.sv
// bcd_serial_adder_ctrl: adds two NDIG-digit packed-BCD operands one digit per clock, LSD first.
module bcd_serial_adder_ctrl
   import bcd_pkg::*;
#(
   parameter int NDIG = 4
) (
   input logic                  clk,
   input logic                  rst,
   bcd_serial_adder_ctrl_if.slave bus
);
   localparam int W = 4*NDIG;
   localparam int IDX_W = NDIG > 1 ? $clog2(NDIG) : 1;
   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               carry_q, carry_d;
   logic [W-1:0]       opa_q, opa_d, opb_q, opb_d, sum_q, sum_d;
   logic               cout_q, cout_d, err_q, err_d;
   logic [DIGIT_W-1:0] dig_s;
   logic               dig_co, dig_bad;
   bcd_digit_add u_add (
      .a_d (get_digit(MAX_W'(opa_q), int'(idx_q))),
      .b_d (get_digit(MAX_W'(opb_q), int'(idx_q))),
      .ci  (carry_q),
      .s   (dig_s),
      .co  (dig_co),
      .bad (dig_bad)
   );
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      err_d   = err_q;
      if (state_q == RUN) begin
         sum_d[DIGIT_W*idx_q +: DIGIT_W] = dig_s;
         carry_d = dig_co;
         err_d   = err_q | dig_bad;
         if (idx_q == IDX_W'(NDIG-1)) begin
            cout_d  = dig_co;
            state_d = DONE;
         end else begin
            idx_d = idx_q + 1'b1;
         end
      end else if (bus.start) begin
         opa_d   = bus.a;
         opb_d   = bus.b;
         carry_d = bus.cin;
         idx_d   = '0;
         sum_d   = '0;
         cout_d  = 1'b0;
         err_d   = 1'b0;
         state_d = RUN;
      end else if (state_q == DONE) begin
         state_d = IDLE;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         carry_q <= 1'b0;
         opa_q   <= '0;
         opb_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         err_q   <= err_d;
      end
   end
   assign bus.busy = state_q == RUN;
   assign bus.done = state_q == DONE;
   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;
   assign bus.err  = err_q;
endmodule
